// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes, bit-serial shifts and registered flags.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier for opcode 0011.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_MUL = 4'b0011,
    OP_SUB = 4'b0110,
    OP_SLL = 4'b1000,
    OP_SRL = 4'b1001,
    OP_SRA = 4'b1011
  } op_t;

  state_t           state, state_n;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q, wrk;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum, diff, res_d;
  logic             ovf_d, accept, is_shift;
`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] acc, mplr;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_shift  = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Every accepted op passes through BUSY; the cycle with cnt==0 is the
  // write-back cycle, which gives the k+1 / k+1+s / k+1+WIDTH latencies.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = BUSY;
      BUSY:    if (cnt == '0) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sum   = a_q + b_q;
    diff  = a_q - b_q;
    res_d = '0;
    ovf_d = 1'b0;
    case (op_q)
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_ADD: begin
        res_d = sum;
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = diff;
        ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLL, OP_SRL, OP_SRA: res_d = wrk;
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: res_d = acc;
`endif
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      wrk      <= '0;
      cnt      <= '0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      acc      <= '0;
      mplr     <= '0;
`endif
    end else if (accept) begin
      op_q <= op_t'(op);
      a_q  <= a;
      b_q  <= b;
      wrk  <= a;
      cnt  <= is_shift ? CW'(b[SHW-1:0]) : '0;
`ifdef SEQ_ALU_MUL_EN
      if (op == OP_MUL) begin
        cnt  <= CW'(WIDTH);
        acc  <= '0;
        mplr <= b;
      end
`endif
    end else if (state == BUSY) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        case (op_q)
          OP_SLL: wrk <= wrk << 1;
          OP_SRL: wrk <= wrk >> 1;
          OP_SRA: wrk <= {wrk[WIDTH-1], wrk[WIDTH-1:1]};
`ifdef SEQ_ALU_MUL_EN
          OP_MUL: begin
            if (mplr[0]) acc <= acc + wrk;
            wrk  <= wrk << 1;
            mplr <= mplr >> 1;
          end
`endif
          default: wrk <= wrk;
        endcase
      end else begin
        result   <= res_d;
        zero     <= (res_d == '0);
        overflow <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results queued at issue, popped when out_valid rises.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        v;
    logic [7:0]  lat;
  } res_t;

  res_t sb[$];

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
    res_t e;
    logic [4:0] s;
    s = y[4:0];
    e = '0;
    e.lat = 8'd1;
    case (o)
      4'b0000: e.r = x & y;
      4'b0001: e.r = x | y;
      4'b0010: begin e.r = x + y; e.v = (x[31] == y[31]) && (e.r[31] != x[31]); end
      4'b0110: begin e.r = x - y; e.v = (x[31] != y[31]) && (e.r[31] != x[31]); end
      4'b1000: begin e.r = x << s; e.lat = 8'd1 + 8'(s); end
      4'b1001: begin e.r = x >> s; e.lat = 8'd1 + 8'(s); end
      4'b1011: begin e.r = $signed(x) >>> s; e.lat = 8'd1 + 8'(s); end
`ifdef SEQ_ALU_MUL_EN
      4'b0011: begin e.r = x * y; e.lat = 8'd33; end
`endif
      default: e.r = '0;
    endcase
    e.z = (e.r == 32'h0);
    return e;
  endfunction

  // Drive one request; returns just after the accepting edge with inputs scrambled.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
    @(negedge clk);
    a = x; b = y; op = o; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom);
  endtask

  // Issue, wait (bounded) for out_valid, pop the expectation; optionally complete the handshake.
  task automatic transact(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o,
                          input bit hold, output res_t got, output res_t exp);
    int n;
    sb.push_back(model(x, y, o));
    issue(x, y, o);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    got.r = result;
    got.z = zero;
    got.v = overflow;
    got.lat = out_valid ? 8'(n) : 8'hFF;
    exp = sb.pop_front();
    if (!hold) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, result, zero, overflow} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h z=%b v=%b want rdy=1 vld=0 res=0 z=0 v=0",
               in_ready, out_valid, result, zero, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith;
    res_t got, exp;
    logic [31:0] xs [4] = '{32'h7FFFFFFF, 32'd5, 32'h1234ABCD, 32'h80000000};
    logic [31:0] ys [4] = '{32'h00000001, 32'd5, 32'h0F0F0F0F, 32'h00000001};
    logic [3:0]  os [4] = '{4'b0010, 4'b0110, 4'b1111, 4'b0110};
    for (int i = 0; i < 4; i++) begin
      transact(xs[i], ys[i], os[i], 1'b0, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL arith[%0d] op=%b got res=%h z=%b v=%b lat=%0d want res=%h z=%b v=%b lat=%0d",
                 i, os[i], got.r, got.z, got.v, got.lat, exp.r, exp.z, exp.v, exp.lat);
      end
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arith_idle got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_shifts;
    res_t got, exp;
    logic [31:0] xs [6] = '{32'h80000000, 32'h80000000, 32'h00000003, 32'h80000001, 32'h40000000, 32'hDEADBEEF};
    logic [31:0] ys [6] = '{32'h00000024, 32'h00000024, 32'h0000001F, 32'hFFFFFFE0, 32'h00000003, 32'h00000001};
    logic [3:0]  os [6] = '{4'b1011, 4'b1001, 4'b1000, 4'b1011, 4'b1011, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      transact(xs[i], ys[i], os[i], 1'b0, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL shift[%0d] op=%b got res=%h z=%b v=%b lat=%0d want res=%h z=%b v=%b lat=%0d",
                 i, os[i], got.r, got.z, got.v, got.lat, exp.r, exp.z, exp.v, exp.lat);
      end
    end
  endtask

  task automatic test_mul;
    res_t got, exp;
    transact(32'h0000FFFF, 32'h00010001, 4'b0011, 1'b0, got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mul got res=%h z=%b v=%b lat=%0d want res=%h z=%b v=%b lat=%0d",
               got.r, got.z, got.v, got.lat, exp.r, exp.z, exp.v, exp.lat);
    end
    transact(32'h00001234, 32'h00000567, 4'b0011, 1'b0, got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mul2 got res=%h z=%b v=%b lat=%0d want res=%h z=%b v=%b lat=%0d",
               got.r, got.z, got.v, got.lat, exp.r, exp.z, exp.v, exp.lat);
    end
  endtask

  task automatic test_backpressure;
    res_t got, exp;
    logic [31:0] held;
    bit bad_stable, bad_rdy, seen;
    transact(32'hCAFEF00D, 32'h0000FFFF, 4'b0000, 1'b1, got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL bp_result got res=%h lat=%0d want res=%h lat=%0d", got.r, got.lat, exp.r, exp.lat);
    end
    held = result;
    bad_stable = 1'b0;
    bad_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 3);
      a = 32'h1; b = 32'h1; op = 4'b0010;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (result !== held || out_valid !== 1'b1) bad_stable = 1'b1;
      if (in_ready !== 1'b0) bad_rdy = 1'b1;
    end
    checks++;
    if (bad_stable) begin
      errors++;
      $display("FAIL bp_stable got res=%h vld=%b want res=%h vld=1", result, out_valid, held);
    end
    checks++;
    if (bad_rdy) begin
      errors++;
      $display("FAIL bp_in_ready got 1 during DONE want 0");
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL bp_ignored_pulse got out_valid=1 want 0");
    end
  endtask

  task automatic test_reset_mid;
    res_t got, exp;
    bit seen;
    issue(32'h00000001, 32'd20, 4'b1000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, result, zero, overflow} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_busy got rdy=%b vld=%b res=%h z=%b v=%b want rdy=1 vld=0 res=0 z=0 v=0",
               in_ready, out_valid, result, zero, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_busy_no_valid got out_valid=1 want 0");
    end
    // Reset while parked in DONE with out_ready low.
    transact(32'hFFFFFFFF, 32'h00000001, 4'b0110, 1'b1, got, exp);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, result, zero, overflow} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_done got rdy=%b vld=%b res=%h z=%b v=%b want rdy=1 vld=0 res=0 z=0 v=0",
               in_ready, out_valid, result, zero, overflow);
    end
    // Reset and in_valid together: nothing may be accepted.
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'h5; b = 32'h6; op = 4'b0010;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_accept_collision got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    res_t got, exp;
    logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1000,
                             4'b1001, 4'b1011, 4'b0011, 4'b0101, 4'b1111};
    logic [31:0] x, y;
    logic [3:0] o;
    for (int i = 0; i < 12; i++) begin
      x = $urandom;
      y = $urandom;
      o = ops[$urandom_range(0, 9)];
      transact(x, y, o, 1'b0, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b[%0d] op=%b a=%h b=%h got res=%h z=%b v=%b lat=%0d want res=%h z=%b v=%b lat=%0d",
                 i, o, x, y, got.r, got.z, got.v, got.lat, exp.r, exp.z, exp.v, exp.lat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_shifts;
    test_mul;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
